// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: data widths,
// default frame parameters and the loader state encoding.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  localparam int                DEF_DEPTH     = 64;
  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  // ST_CHECK is only reachable when the trailing checksum byte is enabled
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } ld_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: keeps the three earlier bytes of the
// current word and flags the cycle in which the fourth byte arrives, when
// the completed word is presented combinationally.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_vld,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-BYTE_W-1:0] sh_q, sh_d;
  logic [1:0]               cnt_q, cnt_d;

  assign word_vld = byte_vld && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word     = {sh_q, byte_in};

  // Next-state: clear wins over shifting so a new frame starts on a word boundary
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_vld) begin
      sh_d  = {sh_q[WORD_W-2*BYTE_W-1:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Shift register and byte counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream
// (SYNC_BYTE, N, 4N data bytes MSB first), writes N words to instruction
// memory from address 0 and releases the CPU only once the image is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (N and all data bytes) that must match before the CPU is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // One extra bit so a count of DEPTH is representable and compares cleanly
  localparam int                IDX_W   = $clog2(DEPTH) + 1;
  localparam logic [BYTE_W:0]   DEPTH_B = (BYTE_W + 1)'(DEPTH);

  ld_state_e         state_q;
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic              wr_en_q;
  logic [WORD_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
`endif

  logic              accept;
  logic              all_words;
  logic              pk_clr;
  logic              pk_vld;
  logic              pk_word_vld;
  logic [WORD_W-1:0] pk_word;

  // All N words collected; the last write is still in flight this cycle
  assign all_words = (word_idx_q == count_q);

  // Stall input while the final word's write pulse is out so no stray
  // byte is swallowed before the state moves on
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_COUNT) ||
                    (state_q == ST_CHECK) ||
                    ((state_q == ST_DATA) && !all_words);
  assign accept   = in_valid && in_ready;

  assign pk_clr   = (state_q == ST_COUNT) && accept;
  assign pk_vld   = (state_q == ST_DATA) && accept;

  imem_loader_byte_packer u_pack (
    .clk      (clk),
    .reset    (reset),
    .clr      (pk_clr),
    .byte_vld (pk_vld),
    .byte_in  (in_data),
    .word_vld (pk_word_vld),
    .word     (pk_word)
  );

  // Frame FSM with registered memory-write and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (accept) begin
            if ((in_data == '0) || ({1'b0, in_data} > DEPTH_B)) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end else begin
              state_q    <= ST_DATA;
              count_q    <= in_data[IDX_W-1:0];
              word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_q     <= in_data;
`endif
            end
          end
        end
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) csum_q <= csum_q ^ in_data;
`endif
          if (pk_word_vld) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= pk_word;
            wr_addr_q  <= {{(WORD_W - IDX_W - 2){1'b0}}, word_idx_q, 2'b00};
            word_idx_q <= word_idx_q + 1'b1;
          end else if (all_words) begin
            // Reached only on the edge that ends the last write pulse
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= ST_CHECK;
`else
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (in_data == csum_q) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= ST_ERR;
              error_q    <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        ST_ERR: begin
          if (start) begin
            state_q <= ST_IDLE;
            error_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, garbage skipping, count
// errors, a full-depth load with input gaps and reset mid-frame.
// Build with IMEM_LOADER_CHECKSUM_EN to exercise the trailing checksum byte.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  frm[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // Record every memory write
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frm(input bit gaps);
    foreach (frm[i]) begin
      if (gaps && i > 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_byte(frm[i]);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] frm_csum();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < frm.size(); i++) x ^= frm[i];
    return x;
  endfunction

  // Bring the frame to DONE: trailing checksum byte if built in,
  // otherwise just the cycle after the final write pulse
  task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(frm_csum());
    in_valid = 1'b0;
`else
    @(negedge clk);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({t, "_wr_en"},    {31'd0, wr_en},    32'd0);
    chk({t, "_wr_addr"},  wr_addr,           32'd0);
    chk({t, "_wr_data"},  wr_data,           32'd0);
    chk({t, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({t, "_done"},     {31'd0, done},     32'd0);
    chk({t, "_error"},    {31'd0, error},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Two-word image, back to back
    frm = '{8'hA5, 8'h02, 8'h20, 8'h09, 8'h00, 8'h26, 8'hAD, 8'h09, 8'h00, 8'h00};
    send_frm(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("t1_last_wr_en",   {31'd0, wr_en},    32'd1);
    chk("t1_done_early",   {31'd0, done},     32'd0);
    chk("t1_hold_early",   {31'd0, cpu_hold}, 32'd1);
`endif
    finish_frame();
    chk("t1_done",         {31'd0, done},     32'd1);
    chk("t1_hold",         {31'd0, cpu_hold}, 32'd0);
    chk("t1_ready_done",   {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("t1_nwr",  wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t1_a0", wa[0], 32'h0000_0000);
      chk("t1_d0", wd[0], 32'h2009_0026);
      chk("t1_a1", wa[1], 32'h0000_0004);
      chk("t1_d1", wd[1], 32'hAD09_0000);
    end

    // Re-arm, leading garbage dropped in IDLE
    pulse_start();
    chk("t2_done_clr", {31'd0, done},     32'd0);
    chk("t2_hold_set", {31'd0, cpu_hold}, 32'd1);
    chk("t2_ready",    {31'd0, in_ready}, 32'd1);
    wa.delete(); wd.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    frm = '{8'hA5, 8'h01, 8'h08, 8'h00, 8'h00, 8'h0E};
    send_frm(0);
    finish_frame();
    @(negedge clk);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_nwr",  wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("t2_a0", wa[0], 32'h0000_0000);
      chk("t2_d0", wd[0], 32'h0800_000E);
    end

    // Count of zero and count above depth both error out
    pulse_start();
    wa.delete(); wd.delete();
    frm = '{8'hA5, 8'h00};
    send_frm(0);
    chk("t3a_error", {31'd0, error},    32'd1);
    chk("t3a_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t3a_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    chk("t3a_err_clr", {31'd0, error},    32'd0);
    chk("t3a_ready2",  {31'd0, in_ready}, 32'd1);
    frm = '{8'hA5, 8'h41};
    send_frm(0);
    chk("t3b_error", {31'd0, error},    32'd1);
    chk("t3b_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t3b_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    chk("t3b_err_clr", {31'd0, error}, 32'd0);
    chk("t3_nwr", wa.size(), 32'd0);

    // Full-depth image with random input gaps
    wa.delete(); wd.delete();
    frm = '{8'hA5, 8'h40};
    for (int j = 0; j < 256; j++) begin
      b = 8'((j * 7 + 3) & 255);
      frm.push_back(b);
    end
    send_frm(1);
    finish_frame();
    @(negedge clk);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_nwr",  wa.size(), 32'd64);
    if (wa.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        w = {8'((4*k*7 + 3) & 255), 8'(((4*k+1)*7 + 3) & 255),
             8'(((4*k+2)*7 + 3) & 255), 8'(((4*k+3)*7 + 3) & 255)};
        chk($sformatf("t4_a%0d", k), wa[k], 32'(k * 4));
        chk($sformatf("t4_d%0d", k), wd[k], w);
      end
      chk("t4_last_addr", wa[63], 32'h0000_00FC);
    end

    // Reset in the middle of the second word
    pulse_start();
    wa.delete(); wd.delete();
    frm = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frm(0);
    repeat (2) @(negedge clk);
    chk("t5_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) chk("t5_d0", wd[0], 32'h1122_3344);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("t5_rst");
    wa.delete(); wd.delete();
    frm = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frm(0);
    finish_frame();
    @(negedge clk);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_nwr2", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("t5_a0", wa[0], 32'h0000_0000);
      chk("t5_d0b", wd[0], 32'hDEAD_BEEF);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Hand-computed checksum 01^12^34^56^78 = 09
    pulse_start();
    wa.delete(); wd.delete();
    frm = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frm(0);
    send_byte(8'h09);
    in_valid = 1'b0;
    chk("t6_done", {31'd0, done},     32'd1);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t6_err",  {31'd0, error},    32'd0);
    pulse_start();
    send_frm(0);
    send_byte(8'h00);
    in_valid = 1'b0;
    chk("t7_err",  {31'd0, error},    32'd1);
    chk("t7_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t7_done", {31'd0, done},     32'd0);
    @(negedge clk);
    chk("t7_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) chk("t7_d1", wd[1], 32'h1234_5678);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
